// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset release sequencer.
// Holds the FSM state encoding, default parameter values and width helpers.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int DEF_N_DOM       = 4;
  localparam int DEF_N_REQ       = 2;
  localparam int DEF_HOLD_CYCLES = 8;
  localparam int DEF_STAGGER     = 2;

  // Counter must reach max(hold, stagger)-1; one spare bit keeps the
  // terminal compare free of overflow corner cases.
  function automatic int cnt_w(input int hold, input int stagger);
    int m;
    m = (hold > stagger) ? hold : stagger;
    return $clog2(m) + 1;
  endfunction

  // Index width for a population of n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_release_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or
// above ptr_i, wrapping to index 0 when nothing at or above ptr_i is requesting.
module rr_arbiter
  import reset_seq_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int PTR_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [PTR_W-1:0] idx_o
);

  logic found;

  // Two passes: first the indices at/above the pointer, then the wrap-around.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_i))) begin
        grant_o[i] = 1'b1;
        idx_o      = PTR_W'(i);
        found      = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i]) begin
        grant_o[i] = 1'b1;
        idx_o      = PTR_W'(i);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: asserts all domain resets, holds them, then releases
// one domain at a time (index 0 first) with a fixed stagger. Soft-reset
// requests are granted round-robin in IDLE and replay the whole sequence.
// Optional macro RST_SEQ_DOM_MASK_EN adds dom_mask: masked domains stay
// released during soft sequences (mask sampled at grant only).
//
// Handshake: req[k] is a level held high until ack[k] pulses for one cycle;
// ack is only issued in IDLE while RESETN is high, and a request seen in any
// other state is simply left pending by the requester.
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOM       = DEF_N_DOM,
  parameter int N_REQ       = DEF_N_REQ,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGGER     = DEF_STAGGER
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [N_REQ-1:0] req,
`ifdef RST_SEQ_DOM_MASK_EN
  input  logic [N_DOM-1:0] dom_mask,
`endif
  output logic [N_REQ-1:0] ack,
  output logic [N_DOM-1:0] rst_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = cnt_w(HOLD_CYCLES, STAGGER);
  localparam int IDX_W = idx_w(N_DOM);
  localparam int PTR_W = idx_w(N_REQ);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_DOM-1:0] rst_q, rst_d;
  logic             done_q, done_d;
  logic [N_REQ-1:0] ack_c;
  logic [N_REQ-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic [N_DOM-1:0] grant_mask;

`ifdef RST_SEQ_DOM_MASK_EN
  assign grant_mask = dom_mask;
`else
  assign grant_mask = '0;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt),
    .idx_o   (gnt_idx)
  );

  // State register; RESETN low aborts any sequence and restarts from ASSERT.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q  <= ASSERT;
      cnt_q    <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      rst_q    <= '1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      rst_q    <= rst_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: hold count, staggered release, round-robin grant in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    rst_d    = rst_q;
    done_d   = done_q;
    ack_c    = '0;
    case (state_q)
      ASSERT: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == CNT_W'(STAGGER - 1)) begin
          cnt_d        = '0;
          rst_d[idx_q] = 1'b0;
          if (idx_q == IDX_W'(N_DOM - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (RESETN && (gnt != '0)) begin
          ack_c    = gnt;
          state_d  = ASSERT;
          cnt_d    = '0;
          idx_d    = '0;
          rst_d    = ~grant_mask;
          done_d   = 1'b0;
          rr_ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
        idx_d   = '0;
        rst_d   = '1;
        done_d  = 1'b0;
      end
    endcase
  end

  assign ack         = ack_c;
  assign rst_out     = rst_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule
